// File: rtl/game_seq_ctrl_if.sv
// game_seq_ctrl_if: sequencer signals; master = sequencer (vsync/btn_start/win/lose in; blk_reload/coll_clr/ball_hold/frame_en/lives/game_state out), slave = surroundings
interface game_seq_ctrl_if;
  logic vsync;
  logic btn_start;
  logic win;
  logic lose;
  logic blk_reload;
  logic coll_clr;
  logic ball_hold;
  logic frame_en;
  logic [1:0] lives;
  logic [2:0] game_state;
  modport master(
    input vsync, btn_start, win, lose,
    output blk_reload, coll_clr, ball_hold, frame_en, lives, game_state
  );
  modport slave(
    output vsync, btn_start, win, lose,
    input blk_reload, coll_clr, ball_hold, frame_en, lives, game_state
  );
endinterface

// File: rtl/game_seq_ctrl.sv
// game_seq_ctrl: breakout start/serve/play/miss/end sequencer; ports pxl_clk, reset_n (sync, active-low), bus (game_seq_ctrl_if.master)
module game_seq_ctrl #(
  parameter int LIVES = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int END_FRAMES = 180
) (
  input logic pxl_clk,
  input logic reset_n,
  game_seq_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    WON   = 3'd4,
    OVER  = 3'd5
  } state_t;
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] END_LAST = 8'(END_FRAMES - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  state_t state, nxt;
  logic [7:0] frm_cnt;
  logic [1:0] lives, lives_nxt;
  logic vsync_d, btn_d, armed, tick, press, reload_nxt, clr_nxt;
  logic blk_reload, coll_clr, frame_en, ball_hold;
  assign tick = bus.vsync & ~vsync_d;
  assign press = bus.btn_start & ~btn_d & armed;
  always_comb begin
    nxt = state;
    lives_nxt = lives;
    reload_nxt = 1'b0;
    clr_nxt = 1'b0;
    case (state)
      IDLE, WON, OVER:
        if (press) begin
          nxt = SERVE;
          reload_nxt = 1'b1;
          clr_nxt = 1'b1;
          lives_nxt = LIVES_INIT;
        end else if (state != IDLE && tick && frm_cnt == END_LAST) nxt = IDLE;
      SERVE: if (tick && frm_cnt == SERVE_LAST) nxt = PLAY;
      PLAY:
        if (bus.win) begin
          nxt = WON;
          clr_nxt = 1'b1;
        end else if (bus.lose) begin
          nxt = (lives > 2'd1) ? MISS : OVER;
          lives_nxt = lives - 2'd1;
          clr_nxt = 1'b1;
        end
      MISS: if (tick && !bus.lose) nxt = SERVE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge pxl_clk) begin
    if (!reset_n) begin
      state <= IDLE;
      lives <= LIVES_INIT;
      frm_cnt <= '0;
      vsync_d <= 1'b0;
      btn_d <= 1'b0;
      armed <= ~bus.btn_start;
      blk_reload <= 1'b0;
      coll_clr <= 1'b0;
      frame_en <= 1'b0;
      ball_hold <= 1'b1;
    end else begin
      state <= nxt;
      lives <= lives_nxt;
      frm_cnt <= (nxt != state) ? 8'd0 : frm_cnt + {7'd0, tick};
      vsync_d <= bus.vsync;
      btn_d <= bus.btn_start;
      armed <= armed | ~bus.btn_start;
      blk_reload <= reload_nxt;
      coll_clr <= clr_nxt;
      frame_en <= tick && state == PLAY && nxt == PLAY;
      ball_hold <= nxt != PLAY;
    end
  end
  assign bus.game_state = state;
  assign bus.lives = lives;
  assign bus.blk_reload = blk_reload;
  assign bus.coll_clr = coll_clr;
  assign bus.frame_en = frame_en;
  assign bus.ball_hold = ball_hold;
endmodule

// File: tb/tb_game_seq_ctrl.sv
// tb_game_seq_ctrl: directed and randomized checks of game_seq_ctrl against a behavioural model
module tb_game_seq_ctrl;
  localparam int LIVES = 3;
  localparam int SF = 60;
  localparam int EF = 180;
  logic pxl_clk = 1'b0;
  logic reset_n = 1'b0;
  game_seq_ctrl_if bus();
  game_seq_ctrl #(.LIVES(LIVES), .SERVE_FRAMES(SF), .END_FRAMES(EF)) dut (
    .pxl_clk(pxl_clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 pxl_clk = ~pxl_clk;
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  int m_st, m_lv, m_cnt;
  logic m_vp, m_bp, m_arm, m_valid = 1'b0;
  logic e_rl, e_clr, e_fe, e_hold;
  always @(posedge pxl_clk) begin : model
    logic tk, pr;
    int ns;
    if (!reset_n) begin
      m_st = 0;
      m_lv = LIVES;
      m_cnt = 0;
      m_vp = 1'b0;
      m_bp = 1'b0;
      m_arm = !bus.btn_start;
      e_rl = 1'b0;
      e_clr = 1'b0;
      e_fe = 1'b0;
      e_hold = 1'b1;
      m_valid = 1'b1;
    end else begin
      tk = bus.vsync && !m_vp;
      pr = bus.btn_start && !m_bp && m_arm;
      ns = m_st;
      e_rl = 1'b0;
      e_clr = 1'b0;
      e_fe = 1'b0;
      if (m_st == 2) begin
        if (bus.win) begin
          ns = 4;
          e_clr = 1'b1;
        end else if (bus.lose) begin
          m_lv = m_lv - 1;
          e_clr = 1'b1;
          ns = (m_lv > 0) ? 3 : 5;
        end else e_fe = tk;
      end else if (m_st == 1) begin
        if (tk && m_cnt == SF - 1) ns = 2;
      end else if (m_st == 3) begin
        if (tk && !bus.lose) ns = 1;
      end else if (pr) begin
        ns = 1;
        e_rl = 1'b1;
        e_clr = 1'b1;
        m_lv = LIVES;
      end else if (m_st != 0 && tk && m_cnt == EF - 1) ns = 0;
      m_cnt = (ns != m_st) ? 0 : m_cnt + int'(tk);
      m_st = ns;
      e_hold = (ns != 2);
      m_vp = bus.vsync;
      m_bp = bus.btn_start;
      if (!bus.btn_start) m_arm = 1'b1;
    end
  end
  always @(negedge pxl_clk) begin
    if (m_valid) begin
      chk("game_state", int'(bus.game_state), m_st);
      chk("lives", int'(bus.lives), m_lv);
      chk("blk_reload", int'(bus.blk_reload), int'(e_rl));
      chk("coll_clr", int'(bus.coll_clr), int'(e_clr));
      chk("frame_en", int'(bus.frame_en), int'(e_fe));
      chk("ball_hold", int'(bus.ball_hold), int'(e_hold));
    end
  end
  int fper = 6;
  int fcnt = 0;
  int n_rl = 0;
  task automatic step();
    @(negedge pxl_clk);
    if (bus.coll_clr) begin
      bus.lose = 1'b0;
      bus.win = 1'b0;
    end
    if (bus.blk_reload) n_rl++;
    fcnt = (fcnt + 1 >= fper) ? 0 : fcnt + 1;
    bus.vsync = (fcnt < 2);
  endtask
  task automatic steps(int n);
    repeat (n) step();
  endtask
  task automatic wait_state(int code, int budget);
    int k = 0;
    while (int'(bus.game_state) != code && k < budget) begin
      step();
      k++;
    end
    chk($sformatf("reach_state_%0d", code), int'(bus.game_state), code);
  endtask
  task automatic press();
    bus.btn_start = 1'b1;
    step();
    bus.btn_start = 1'b0;
  endtask
  task automatic lose_once();
    wait_state(2, 500);
    bus.lose = 1'b1;
    step();
  endtask
  initial begin
    int fe, r0;
    bus.vsync = 1'b0;
    bus.btn_start = 1'b1;
    bus.win = 1'b0;
    bus.lose = 1'b0;
    steps(3);
    reset_n = 1'b1;
    steps(4);
    chk("held_btn_no_press", int'(bus.game_state), 0);
    chk("reset_lives", int'(bus.lives), 3);
    chk("reset_hold", int'(bus.ball_hold), 1);
    bus.btn_start = 1'b0;
    steps(2);
    press();
    chk("press_reload", int'(bus.blk_reload), 1);
    chk("press_clr", int'(bus.coll_clr), 1);
    chk("press_state", int'(bus.game_state), 1);
    chk("press_lives", int'(bus.lives), 3);
    step();
    chk("reload_width", int'(bus.blk_reload), 0);
    chk("clr_width", int'(bus.coll_clr), 0);
    steps(55 * 6);
    chk("serve_still_55", int'(bus.game_state), 1);
    wait_state(2, 100);
    chk("play_hold", int'(bus.ball_hold), 0);
    fe = 0;
    repeat (30) begin
      step();
      fe += int'(bus.frame_en);
    end
    chk("frame_en_count", fe, 5);
    r0 = n_rl;
    bus.lose = 1'b1;
    step();
    chk("miss_clr", int'(bus.coll_clr), 1);
    chk("miss_lives", int'(bus.lives), 2);
    chk("miss_state", int'(bus.game_state), 3);
    wait_state(1, 50);
    chk("miss_no_reload", n_rl, r0);
    lose_once();
    chk("miss2_lives", int'(bus.lives), 1);
    lose_once();
    chk("over_state", int'(bus.game_state), 5);
    chk("over_lives", int'(bus.lives), 0);
    steps(170 * 6);
    chk("over_still_170", int'(bus.game_state), 5);
    wait_state(0, 100);
    press();
    repeat (3) lose_once();
    chk("over2_state", int'(bus.game_state), 5);
    steps(10 * 6);
    press();
    chk("over_press_state", int'(bus.game_state), 1);
    chk("over_press_lives", int'(bus.lives), 3);
    wait_state(2, 500);
    bus.win = 1'b1;
    bus.lose = 1'b1;
    step();
    chk("won_state", int'(bus.game_state), 4);
    chk("won_lives", int'(bus.lives), 3);
    press();
    wait_state(2, 500);
    lose_once();
    wait_state(2, 500);
    while (fcnt != 0) step();
    reset_n = 1'b0;
    step();
    chk("rst_state", int'(bus.game_state), 0);
    chk("rst_lives", int'(bus.lives), 3);
    chk("rst_hold", int'(bus.ball_hold), 1);
    chk("rst_frame_en", int'(bus.frame_en), 0);
    reset_n = 1'b1;
    repeat (20000) begin
      step();
      if ($urandom % 40 == 0) bus.btn_start = ~bus.btn_start;
      if ($urandom % 80 == 0) bus.lose = 1'b1;
      if ($urandom % 400 == 0) bus.win = 1'b1;
      reset_n = ($urandom % 3000) != 0;
      if (fcnt == 0) fper = $urandom_range(3, 9);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
